// File: rtl/remote_comm_pkg.sv
// Shared constants and state encodings for the remote command sender
// and its UART transceiver.
package remote_comm_pkg;

  localparam int BAUD_DIV_DEFAULT = 434;
  localparam logic [7:0] POS_ACK = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } cmd_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA
  } rx_state_t;

endpackage

// File: rtl/remote_comm_if.sv
// Host-side command/response handshake of remote_comm; the host is the master
// and remote_comm is the slave.
interface remote_comm_if;

  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output send_cmd,
    input  cmd_sent,
    input  resp_rdy,
    input  resp
  );

  modport slave (
    input  cmd,
    input  send_cmd,
    output cmd_sent,
    output resp_rdy,
    output resp
  );

endinterface

// File: rtl/remote_comm_uart.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one
// baud divisor. tx_done pulses for one clock at the end of the stop bit.
module remote_comm_uart
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rdy,
  input  logic       clr_rdy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_DIV / 2 - 1);

  logic             tx_busy_reg;
  logic [9:0]       tx_shift_reg;
  logic [CNT_W-1:0] tx_cnt_reg;
  logic [3:0]       tx_bit_reg;
  logic             tx_done_reg;

  // The frame is pre-built as {stop, data, start}; shifting in ones keeps
  // the line idle high once the stop bit has gone out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_reg  <= 1'b0;
      tx_shift_reg <= '1;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_done_reg  <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      if (!tx_busy_reg) begin
        if (trmt) begin
          tx_busy_reg  <= 1'b1;
          tx_shift_reg <= {1'b1, tx_data, 1'b0};
          tx_cnt_reg   <= '0;
          tx_bit_reg   <= '0;
        end
      end else if (tx_cnt_reg == BIT_END) begin
        tx_cnt_reg <= '0;
        if (tx_bit_reg == 4'd9) begin
          tx_busy_reg <= 1'b0;
          tx_done_reg <= 1'b1;
        end else begin
          tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
          tx_bit_reg   <= tx_bit_reg + 4'd1;
        end
      end else begin
        tx_cnt_reg <= tx_cnt_reg + 1'b1;
      end
    end
  end

  assign tx      = tx_shift_reg[0];
  assign tx_done = tx_done_reg;

  logic             rx_ff1_reg, rx_ff2_reg, rx_prev_reg;
  rx_state_t        rx_state_reg;
  logic [CNT_W-1:0] rx_cnt_reg;
  logic [3:0]       rx_bit_reg;
  logic [7:0]       rx_shift_reg;
  logic [7:0]       rx_data_reg;
  logic             rdy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1_reg   <= 1'b1;
      rx_ff2_reg   <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rdy_reg      <= 1'b0;
    end else begin
      rx_ff1_reg  <= rx;
      rx_ff2_reg  <= rx_ff1_reg;
      rx_prev_reg <= rx_ff2_reg;
      if (clr_rdy) rdy_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_ff2_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
            rdy_reg      <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_END) begin
            rx_cnt_reg <= '0;
            rx_bit_reg <= '0;
            rx_state_reg <= rx_ff2_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          // Ninth centre sample is the stop bit: deliver without checking it.
          if (rx_cnt_reg == BIT_END) begin
            rx_cnt_reg <= '0;
            if (rx_bit_reg == 4'd8) begin
              rx_data_reg  <= rx_shift_reg;
              rdy_reg      <= 1'b1;
              rx_state_reg <= RX_IDLE;
            end else begin
              rx_shift_reg <= {rx_ff2_reg, rx_shift_reg[7:1]};
              rx_bit_reg   <= rx_bit_reg + 4'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign rx_data = rx_data_reg;
  assign rdy     = rdy_reg;

endmodule

// File: rtl/remote_comm.sv
// Host-side command sender: ships a 16-bit command as two UART bytes (high
// byte first) and presents single-byte responses received on RX.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  output logic          TX,
  remote_comm_if.slave  host
);

  cmd_state_t state_reg;
  logic [7:0] low_reg;
  logic [7:0] tx_data_reg;
  logic       trmt_reg;
  logic       cmd_sent_reg;
  logic       tx_done;

  remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .tx      (TX),
    .tx_data (tx_data_reg),
    .trmt    (trmt_reg),
    .tx_done (tx_done),
    .rx_data (host.resp),
    .rdy     (host.resp_rdy),
    .clr_rdy (host.send_cmd)
  );

  // send_cmd outside IDLE is ignored so the in-flight command finishes intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      low_reg      <= '0;
      tx_data_reg  <= '0;
      trmt_reg     <= 1'b0;
      cmd_sent_reg <= 1'b0;
    end else begin
      trmt_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (host.send_cmd) begin
            low_reg      <= host.cmd[7:0];
            tx_data_reg  <= host.cmd[15:8];
            trmt_reg     <= 1'b1;
            cmd_sent_reg <= 1'b0;
            state_reg    <= HIGH;
          end
        end
        HIGH: begin
          if (tx_done) begin
            tx_data_reg <= low_reg;
            trmt_reg    <= 1'b1;
            state_reg   <= LOW;
          end
        end
        LOW: begin
          if (tx_done) begin
            cmd_sent_reg <= 1'b1;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign host.cmd_sent = cmd_sent_reg;

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: decodes TX frames and received responses
// against queues of expected bytes filled when stimulus is driven.
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int B = BAUD_DIV_DEFAULT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line = 1'b1;
  logic loopback = 1'b0;
  logic tx;
  logic rx;

  assign rx = loopback ? tx : rx_line;

  remote_comm_if bus();

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .TX    (tx),
    .host  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int cycle = 0;
  logic rst_seen = 1'b0;

  always @(posedge clk) cycle++;
  always @(negedge rst_n) rst_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Response and cmd_sent edge monitor
  logic rdy_prev = 1'b0;
  logic sent_prev = 1'b0;
  int rdy_rises = 0;
  int sent_rises = 0;
  int rdy_cycle = 0;

  always @(negedge clk) begin
    if (bus.resp_rdy === 1'b1 && rdy_prev !== 1'b1) begin
      rdy_rises++;
      rdy_cycle = cycle;
      $display("RX resp 0x%02h at cycle %0d", bus.resp, cycle);
      if (rx_exp.size() == 0) check("resp_unexpected", 32'(bus.resp_rdy), 32'h0);
      else check("resp", 32'(bus.resp), 32'(rx_exp.pop_front()));
    end
    if (bus.cmd_sent === 1'b1 && sent_prev !== 1'b1) sent_rises++;
    rdy_prev = bus.resp_rdy;
    sent_prev = bus.cmd_sent;
  end

  // TX frame decoder, sampling at bit centres on the falling clock edge
  initial begin : tx_mon
    logic [7:0] d;
    logic stop_bit;
    forever begin
      @(negedge tx);
      if (rst_n !== 1'b1) continue;
      rst_seen = 1'b0;
      repeat (B / 2) @(negedge clk);
      if (tx !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        repeat (B) @(negedge clk);
        d[i] = tx;
      end
      repeat (B) @(negedge clk);
      stop_bit = tx;
      if (rst_seen) begin
        $display("TX frame discarded by reset");
        continue;
      end
      $display("TX frame 0x%02h at cycle %0d", d, cycle);
      check("tx_stop", 32'(stop_bit), 32'h1);
      if (tx_exp.size() == 0) check("tx_unexpected", {24'h0, d}, 32'h100);
      else check("tx_byte", 32'(d), 32'(tx_exp.pop_front()));
    end
  end

  task automatic send(input logic [15:0] c);
    @(negedge clk);
    bus.cmd = c;
    bus.send_cmd = 1'b1;
    @(negedge clk);
    bus.send_cmd = 1'b0;
  endtask

  task automatic wait_sent(input string tag, output int lat);
    lat = 0;
    while (bus.cmd_sent !== 1'b1 && lat < 20 * B + 100) begin
      @(negedge clk);
      lat++;
    end
    check(tag, 32'(bus.cmd_sent), 32'h1);
  endtask

  task automatic wait_tx_empty(input string tag);
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < 12 * B) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_exp.size()), 32'h0);
  endtask

  task automatic uart_send(input logic [7:0] b, output int start_cyc);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    @(negedge clk);
    start_cyc = cycle;
    for (int i = 0; i < 10; i++) begin
      rx_line = f[i];
      repeat (B) @(negedge clk);
    end
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int start_cyc;
    int bad;
    int r0;
    int s0;
    int n;

    bus.cmd = 16'h0000;
    bus.send_cmd = 1'b0;

    // Reset and idle hold
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_cmd_sent", 32'(bus.cmd_sent), 32'h0);
    check("reset_resp_rdy", 32'(bus.resp_rdy), 32'h0);
    check("reset_resp", 32'(bus.resp), 32'h0);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.cmd_sent !== 1'b0 || bus.resp_rdy !== 1'b0 || bus.resp !== 8'h00) bad++;
    end
    check("reset_idle_hold", 32'(bad), 32'h0);

    // Basic command
    tx_exp.push_back(8'h20);
    tx_exp.push_back(8'h00);
    send(16'h2000);
    wait_sent("cmd_2000_sent", lat);
    $display("cmd 0x2000 sent after %0d clocks", lat);
    check("cmd_sent_latency_ok", 32'(lat <= 20 * B + 5), 32'h1);
    wait_tx_empty("cmd_2000_frames");

    // Loopback
    loopback = 1'b1;
    tx_exp.push_back(8'hA5);
    tx_exp.push_back(8'h5A);
    rx_exp.push_back(8'hA5);
    rx_exp.push_back(8'h5A);
    r0 = rdy_rises;
    send(16'hA55A);
    wait_sent("loop_sent", lat);
    repeat (5) @(negedge clk);
    check("loop_rdy_count", 32'(rdy_rises - r0), 32'h2);
    check("loop_final_resp", 32'(bus.resp), 32'h5A);
    check("loop_rx_queue", 32'(rx_exp.size()), 32'h0);
    wait_tx_empty("loop_frames");
    loopback = 1'b0;
    repeat (10) @(negedge clk);

    // External response
    check("cmd_sent_holds", 32'(bus.cmd_sent), 32'h1);
    rx_exp.push_back(POS_ACK);
    uart_send(POS_ACK, start_cyc);
    $display("ack rx latency %0d clocks", rdy_cycle - start_cyc);
    check("ack_latency_ok", 32'((rdy_cycle - start_cyc) >= (19 * B) / 2 - 10 && (rdy_cycle - start_cyc) <= (19 * B) / 2 + 10), 32'h1);
    check("ack_rdy", 32'(bus.resp_rdy), 32'h1);
    check("ack_resp", 32'(bus.resp), 32'(POS_ACK));

    // Busy ignore; also checks send_cmd clears resp_rdy and cmd_sent
    tx_exp.push_back(8'h43);
    tx_exp.push_back(8'h21);
    s0 = sent_rises;
    send(16'h4321);
    check("rdy_clr_on_send", 32'(bus.resp_rdy), 32'h0);
    check("cmd_sent_clr_on_send", 32'(bus.cmd_sent), 32'h0);
    repeat (3 * B) @(negedge clk);
    send(16'h1234);
    wait_sent("busy_sent", lat);
    repeat (11 * B) @(negedge clk);
    check("busy_sent_once", 32'(sent_rises - s0), 32'h1);
    check("busy_tx_queue", 32'(tx_exp.size()), 32'h0);

    // Mid-frame reset during the low byte
    tx_exp.push_back(8'h13);
    send(16'h1357);
    wait_tx_empty("rst_high_frame");
    n = 0;
    while (tx !== 1'b0 && n < 2 * B) begin
      @(negedge clk);
      n++;
    end
    check("rst_low_started", 32'(tx), 32'h0);
    repeat (B / 4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx_immediate", 32'(tx), 32'h1);
    s0 = sent_rises;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * B) @(negedge clk);
    check("rst_no_cmd_sent", 32'(sent_rises - s0), 32'h0);
    check("rst_tx_idle", 32'(tx), 32'h1);
    tx_exp.push_back(8'h0F);
    tx_exp.push_back(8'hF0);
    send(16'h0FF0);
    wait_sent("post_rst_sent", lat);
    wait_tx_empty("post_rst_frames");

    check("final_rx_queue", 32'(rx_exp.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
